// File: rtl/simprisc_pkg.sv
// simprisc_pkg: shared types and helpers for the SimpRisc fetch front end.
//   XLEN_DEFAULT  - default address/instruction width
//   fetch_entry_t - {pc, instr} pair buffered between fetch and decode
//   sat_add32     - saturating 32-bit add used by the statistics counters
package simprisc_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch entries with a flush input.
//   clk, reset     - clock, synchronous active-high reset
//   flush_i        - empty the FIFO at the clock edge (wins over push/pop)
//   push_i/data_i  - write one entry
//   pop_i          - remove the head entry (must only be raised when !empty_o)
//   empty_o        - no entries held
//   head_o         - oldest entry; stable until popped or flushed
//   count_o        - entries held, 0..DEPTH
module fetch_fifo
  import simprisc_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  entry_t                   data_i,
  input  logic                     pop_i,
  output logic                     empty_o,
  output entry_t                   head_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
      cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

  // The issue credit rule in the parent keeps occupancy bounded.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset || flush_i)
    !(push_i && !pop_i && cnt_q == CW'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset || flush_i)
    !(pop_i && cnt_q == '0));

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: SimpRisc instruction-fetch front end.
// Owns the PC, issues sequential fetches to a 1-cycle-latency instruction
// memory, buffers {pc, instr} pairs and hands them to decode over valid/ready.
// A redirect from execute flushes the queue and restarts fetch.
//   clk, reset                - clock, synchronous active-high reset
//   imem_req/imem_addr        - fetch request and address (= pc)
//   imem_rdata                - instruction, valid the cycle after imem_req
//   redirect_valid/redirect_pc- flush and restart at redirect_pc
//   dec_valid/dec_ready       - decode handshake; dec_pc/dec_instr = head entry
//   fetch_count/flush_count   - delivered / discarded entry counters,
//                               present only when FETCH_STATS_EN is defined
module fetch_queue
  import simprisc_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              DEPTH    = 4,
  parameter int              PC_STEP  = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_pc,
  output logic [XLEN-1:0] dec_instr
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]     fetch_count,
  output logic [31:0]     flush_count
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  logic [XLEN-1:0] pc_q, req_pc_q;
  logic            inflight_q, drop_q;
  logic            empty, push, pop, issue;
  logic [CW-1:0]   count;
  logic [CW:0]     used;
  entry_t          head, push_data;

  // Credit: queued entries plus the outstanding response must leave room.
  assign used      = {1'b0, count} + {{CW{1'b0}}, inflight_q};
  assign issue     = !reset && !redirect_valid && (used < (CW+1)'(DEPTH));
  assign imem_req  = issue;
  assign imem_addr = pc_q;

  // A stale response lands in the redirect cycle itself (1-cycle memory),
  // so redirect_valid suppresses it; drop_q guards the cycle after as well.
  assign push      = inflight_q && !drop_q && !redirect_valid;
  assign push_data = '{pc: req_pc_q, instr: imem_rdata};
  assign pop       = !empty && dec_ready;

  fetch_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (redirect_valid),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .empty_o (empty),
    .head_o  (head),
    .count_o (count)
  );

  assign dec_valid = !empty;
  assign dec_pc    = head.pc;
  assign dec_instr = head.instr;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
    end else if (redirect_valid) begin
      pc_q       <= redirect_pc;
      inflight_q <= 1'b0;
      drop_q     <= inflight_q;
    end else begin
      inflight_q <= issue;
      drop_q     <= 1'b0;
      if (issue) begin
        req_pc_q <= pc_q;
        pc_q     <= pc_q + XLEN'(PC_STEP);
      end
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_cnt_q, flush_cnt_q;
  logic [31:0] flushed;

  // Entries lost to a redirect: what remains after this cycle's pop,
  // plus the response arriving in the same cycle.
  assign flushed = 32'(count) - 32'(pop) + 32'(inflight_q && !drop_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pop)            fetch_cnt_q <= sat_add32(fetch_cnt_q, 32'd1);
      if (redirect_valid) flush_cnt_q <= sat_add32(flush_cnt_q, flushed);
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus randomized traffic checked
// against a queue-based behavioural model. FETCH_STATS_EN enables counter checks.
module tb_fetch_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] K     = 32'hA5A5_0000;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, redirect_valid, dec_ready;
  logic [31:0] redirect_pc;
  logic        imem_req, dec_valid;
  logic [31:0] imem_addr, imem_rdata, dec_pc, dec_instr;

  logic        w_redirect = 1'b0, w_ready = 1'b1;
  logic [31:0] w_rpc = 32'h0;
  logic        w_req, w_dv;
  logic [31:0] w_addr, w_rdata, w_pc, w_instr;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count, flush_count, w_fc, w_flc;
`endif

  fetch_queue dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc), .dec_instr(dec_instr)
`ifdef FETCH_STATS_EN
    , .fetch_count(fetch_count), .flush_count(flush_count)
`endif
  );

  fetch_queue #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .reset(reset), .imem_req(w_req), .imem_addr(w_addr),
    .imem_rdata(w_rdata), .redirect_valid(w_redirect), .redirect_pc(w_rpc),
    .dec_valid(w_dv), .dec_ready(w_ready), .dec_pc(w_pc), .dec_instr(w_instr)
`ifdef FETCH_STATS_EN
    , .fetch_count(w_fc), .flush_count(w_flc)
`endif
  );

  // Instruction memory: 1-cycle latency, data = addr ^ K, garbage otherwise.
  always @(posedge clk) begin
    imem_rdata <= imem_req ? (imem_addr ^ K) : $urandom;
    w_rdata    <= w_req ? (w_addr ^ K) : $urandom;
  end

  // Behavioural model: PC, one outstanding fetch, and a queue of entries.
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc, m_req_pc, m_fc, m_flc;
  bit          m_inf;

  always @(posedge clk) begin : model
    bit req;
    longint fl;
    req = !reset && !redirect_valid && (mq.size() + int'(m_inf) < DEPTH);
    if (reset) begin
      mq.delete(); m_pc = 32'h0; m_inf = 0; m_fc = 0; m_flc = 0; m_req_pc = 0;
    end else begin
      if (mq.size() > 0 && dec_ready) begin
        void'(mq.pop_front());
        if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
      end
      if (redirect_valid) begin
        fl = longint'(m_flc) + mq.size() + int'(m_inf);
        m_flc = (fl > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : fl[31:0];
        mq.delete(); m_pc = redirect_pc; m_inf = 0;
      end else begin
        if (m_inf) mq.push_back('{pc: m_req_pc, instr: m_req_pc ^ K});
        if (req) begin m_req_pc = m_pc; m_pc = m_pc + 32'd4; end
        m_inf = req;
      end
    end
  end

  int          errors = 0, checks = 0;
  logic        e_req, e_dv;
  logic [31:0] e_addr, e_pc, e_ins;

  // Drive one cycle of inputs and compute the model's expected outputs.
  task automatic drive(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    reset = rst; redirect_valid = rv; redirect_pc = rpc; dec_ready = rdy;
    e_req  = !rst && !rv && (mq.size() + int'(m_inf) < DEPTH);
    e_addr = m_pc;
    e_dv   = mq.size() > 0;
    e_pc   = e_dv ? mq[0].pc : 32'h0;
    e_ins  = e_dv ? mq[0].instr : 32'h0;
    #1;
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0);
      checks++;
      if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
    end
    drive(0, 0, 0, 0);
    checks++;
    if (dec_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL reset_state: dv=%b req=%b addr=%h want 0/1/0", dec_valid, imem_req, imem_addr);
    end
`ifdef FETCH_STATS_EN
    checks++;
    if (fetch_count !== 0 || flush_count !== 0) begin
      errors++; $display("FAIL reset_counters: %0d %0d want 0 0", fetch_count, flush_count);
    end
`endif
  endtask

  task automatic test_stream();
    logic [31:0] a;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, 0, 1);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i)) begin
        errors++; $display("FAIL stream_issue[%0d]: req=%b addr=%h want 1 %h", i, imem_req, imem_addr, 32'(4 * i));
      end
      checks++;
      if (i < 2) begin
        if (dec_valid !== 1'b0) begin errors++; $display("FAIL stream_latency[%0d]: dv=%b want 0", i, dec_valid); end
      end else begin
        a = 32'(4 * (i - 2));
        if (dec_valid !== 1'b1 || dec_pc !== a || dec_instr !== (a ^ K)) begin
          errors++; $display("FAIL stream_deliver[%0d]: dv=%b pc=%h ins=%h want 1 %h %h", i, dec_valid, dec_pc, dec_instr, a, a ^ K);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int issued = 0, got = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0);
      if (imem_req === 1'b1) issued++;
      checks++;
      if (imem_req !== e_req || (dec_valid === 1'b1 && dec_pc !== 32'h0)) begin
        errors++; $display("FAIL bp_hold[%0d]: req=%b want %b pc=%h", i, imem_req, e_req, dec_pc);
      end
    end
    checks++;
    if (issued != 4 || imem_req !== 1'b0) begin
      errors++; $display("FAIL bp_credit: issued=%0d req=%b want 4 0", issued, imem_req);
    end
    for (int i = 0; i < 20 && got < 5; i++) begin
      drive(0, 0, 0, 1);
      if (dec_valid === 1'b1) begin
        checks++;
        if (dec_pc !== 32'(4 * got) || dec_instr !== (32'(4 * got) ^ K)) begin
          errors++; $display("FAIL bp_order[%0d]: pc=%h want %h", got, dec_pc, 32'(4 * got));
        end
        got++;
      end
    end
    checks++;
    if (got != 5) begin errors++; $display("FAIL bp_count: got %0d want 5", got); end
  endtask

  task automatic test_redirect();
    int n = 0;
    bit seen = 0;
    do_reset();
    while (!(mq.size() == 3 && m_inf) && n < 12) begin drive(0, 0, 0, 0); n++; end
    checks++;
    if (n >= 12) begin errors++; $display("FAIL redir_setup: occupancy 3+1 not reached, got %0d", mq.size()); end
    drive(0, 1, 32'h100, 0);
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_noissue: req=%b want 0", imem_req); end
    drive(0, 0, 0, 1);
    checks++;
    if (dec_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      errors++; $display("FAIL redir_restart: dv=%b req=%b addr=%h want 0 1 100", dec_valid, imem_req, imem_addr);
    end
`ifdef FETCH_STATS_EN
    checks++;
    if (flush_count !== 32'd4) begin errors++; $display("FAIL redir_flushcnt: %0d want 4", flush_count); end
`endif
    for (int i = 0; i < 6 && !seen; i++) begin
      drive(0, 0, 0, 1);
      if (dec_valid === 1'b1) begin
        seen = 1;
        checks++;
        if (dec_pc !== 32'h100 || dec_instr !== (32'h100 ^ K)) begin
          errors++; $display("FAIL redir_first: pc=%h ins=%h want 100 %h", dec_pc, dec_instr, 32'h100 ^ K);
        end
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL redir_timeout: no delivery after redirect, got none want 100"); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_a [4];
    exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0; exp_a[3] = 32'h4;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1);
      checks++;
      if (w_req !== 1'b1 || w_addr !== exp_a[i]) begin
        errors++; $display("FAIL wrap_addr[%0d]: req=%b addr=%h want 1 %h", i, w_req, w_addr, exp_a[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int got = 0;
    do_reset();
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 1);
    drive(0, 1, 32'h40, 1);
    drive(0, 1, 32'h80, 1);
    checks++;
    if (dec_valid !== 1'b0 || imem_req !== 1'b0) begin
      errors++; $display("FAIL b2b_second: dv=%b req=%b want 0 0", dec_valid, imem_req);
    end
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 1);
      if (imem_req === 1'b1) begin
        checks++;
        if (imem_addr !== 32'(32'h80 + 4 * i)) begin
          errors++; $display("FAIL b2b_issue[%0d]: addr=%h want %h", i, imem_addr, 32'(32'h80 + 4 * i));
        end
      end
      if (dec_valid === 1'b1) begin
        checks++;
        if (dec_pc !== 32'(32'h80 + 4 * got)) begin
          errors++; $display("FAIL b2b_deliver[%0d]: pc=%h want %h", got, dec_pc, 32'(32'h80 + 4 * got));
        end
        got++;
      end
    end
    checks++;
    if (got != 8) begin errors++; $display("FAIL b2b_count: got %0d want 8", got); end
  endtask

  task automatic test_reset_midop();
    int n = 0;
    do_reset();
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1);
    while (!(mq.size() == 3 && m_inf) && n < 12) begin drive(0, 0, 0, 0); n++; end
    drive(1, 0, 0, 0);
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL midrst_req: req=%b want 0", imem_req); end
    drive(0, 0, 0, 1);
    checks++;
    if (dec_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL midrst_restart: dv=%b req=%b addr=%h want 0 1 0", dec_valid, imem_req, imem_addr);
    end
`ifdef FETCH_STATS_EN
    checks++;
    if (fetch_count !== 0 || flush_count !== 0) begin
      errors++; $display("FAIL midrst_counters: %0d %0d want 0 0", fetch_count, flush_count);
    end
`endif
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);
    checks++;
    if (dec_valid !== 1'b1 || dec_pc !== 32'h0) begin
      errors++; $display("FAIL midrst_first: dv=%b pc=%h want 1 0", dec_valid, dec_pc);
    end
  endtask

  task automatic test_random();
    logic rst, rv, rdy;
    logic [31:0] rpc;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom % 60) == 0;
      rv  = ($urandom % 10) == 0;
      rpc = $urandom & 32'hFFFF_FFFC;
      rdy = ($urandom % 3) != 0;
      drive(rst, rv, rpc, rdy);
      checks++;
      if (imem_req !== e_req || imem_addr !== e_addr || dec_valid !== e_dv) begin
        errors++; $display("FAIL rand_ctl[%0d]: req=%b addr=%h dv=%b want %b %h %b", i, imem_req, imem_addr, dec_valid, e_req, e_addr, e_dv);
      end
      if (e_dv) begin
        checks++;
        if (dec_pc !== e_pc || dec_instr !== e_ins) begin
          errors++; $display("FAIL rand_head[%0d]: pc=%h ins=%h want %h %h", i, dec_pc, dec_instr, e_pc, e_ins);
        end
      end
`ifdef FETCH_STATS_EN
      checks++;
      if (fetch_count !== m_fc || flush_count !== m_flc) begin
        errors++; $display("FAIL rand_cnt[%0d]: %0d %0d want %0d %0d", i, fetch_count, flush_count, m_fc, m_flc);
      end
`endif
    end
  endtask

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; dec_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
